// File: rtl/sram_access_sequencer.sv
// Sequencer that drives an asynchronous 8-bit SRAM through programmable setup,
// pulse and hold phases, one request at a time, from registered pin outputs.
module sram_access_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [7:0] A,
    inout  wire  [7:0] DQ,
    output logic       CE,
    output logic       WE,
    output logic       OE
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
            $error("SETUP_CYC must be in 1..15");
        end
        if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
            $error("PULSE_CYC must be in 1..15");
        end
        if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
            $error("HOLD_CYC must be in 1..15");
        end
    endgenerate

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       accept;
    logic       we_lat;
    logic       we_next;
    logic [7:0] wdata_lat;
    logic       dq_en;
    logic       ce_pin_next;
    logic       we_pin_next;
    logic       oe_pin_next;
    logic       dq_en_next;
    logic       rsp_next;
    logic       capture;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign DQ        = dq_en ? wdata_lat : 8'hzz;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Pin levels are decoded from the next state so every strobe leaves a flop.
        we_next     = accept ? req_we : we_lat;
        ce_pin_next = (state_next == IDLE);
        we_pin_next = !((state_next == PULSE) && we_next);
        oe_pin_next = !(((state_next == SETUP) || (state_next == PULSE)) && !we_next);
        dq_en_next  = !ce_pin_next && we_next;
        rsp_next    = (state == HOLD) && (cnt == 4'd0);
        capture     = (state == PULSE) && (cnt == 4'd0) && !we_lat;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_lat    <= 1'b0;
            CE        <= 1'b1;
            WE        <= 1'b1;
            OE        <= 1'b1;
            dq_en     <= 1'b0;
            A         <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            we_lat    <= we_next;
            CE        <= ce_pin_next;
            WE        <= we_pin_next;
            OE        <= oe_pin_next;
            dq_en     <= dq_en_next;
            rsp_valid <= rsp_next;
            if (accept) begin
                A <= req_addr;
            end
            if (capture) begin
                rsp_rdata <= DQ;
            end
        end
    end

    // Write data only matters while dq_en is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_lat <= req_wdata;
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: a default-timing instance driven from a
// vector table with a response scoreboard, and an S=2/P=3/H=2 instance.
module tb_sram_access_sequencer;

    localparam int S0 = 1, P0 = 2, H0 = 1, T0 = S0 + P0 + H0 + 1;
    localparam int S1 = 2, P1 = 3, H1 = 2, T1 = S1 + P1 + H1 + 1;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         gap;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    int         cyc = 0;

    logic       rv0 = 1'b0, rwe0 = 1'b0;
    logic [7:0] raddr0 = 8'h00, rwd0 = 8'h00;
    logic       rr0, rspv0, busy0, ce0, we0, oe0;
    logic [7:0] rspd0, a0;
    wire  [7:0] dq0;

    logic       rv1 = 1'b0, rwe1 = 1'b0;
    logic [7:0] raddr1 = 8'h00, rwd1 = 8'h00;
    logic       rr1, rspv1, busy1, ce1, we1, oe1;
    logic [7:0] rspd1, a1;
    wire  [7:0] dq1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] shadow0 [256];
    logic [7:0] last_rd0 = 8'h00;
    exp_t       sb0 [$];

    int checks = 0, failures = 0;
    int viol = 0, rsp0_cnt = 0, rsp1_cnt = 0, n_acc0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pullup (dq0);
    pullup (dq1);

    // Asynchronous SRAM models: read drives DQ while CE and OE are low.
    assign dq0 = (!ce0 && !oe0) ? mem0[a0] : 8'hzz;
    assign dq1 = (!ce1 && !oe1) ? mem1[a1] : 8'hzz;
    always @(posedge clk) if (!ce0 && !we0) mem0[a0] <= dq0;
    always @(posedge clk) if (!ce1 && !we1) mem1[a1] <= dq1;

    sram_access_sequencer #(.SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0)) dut0 (
        .clk(clk), .clr_n(clr_n), .req_valid(rv0), .req_ready(rr0), .req_we(rwe0),
        .req_addr(raddr0), .req_wdata(rwd0), .rsp_valid(rspv0), .rsp_rdata(rspd0),
        .busy(busy0), .A(a0), .DQ(dq0), .CE(ce0), .WE(we0), .OE(oe0)
    );

    sram_access_sequencer #(.SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1)) dut1 (
        .clk(clk), .clr_n(clr_n), .req_valid(rv1), .req_ready(rr1), .req_we(rwe1),
        .req_addr(raddr1), .req_wdata(rwd1), .rsp_valid(rspv1), .rsp_rdata(rspd1),
        .busy(busy1), .A(a1), .DQ(dq1), .CE(ce1), .WE(we1), .OE(oe1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] mask(input int lo, input int hi);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic wait_ready(input int inst, output int acc);
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (clr_n && ((inst == 0) ? rr0 : rr1)) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) fail_now($sformatf("handshake_timeout_inst%0d", inst));
    endtask

    // Scoreboard pop plus strobe invariants, sampled mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (cyc > 0) begin
            if ((!we0 && !oe0) || (!we0 && ce0) || (!we1 && !oe1) || (!we1 && ce1)) viol++;
            if (rspv0) begin
                rsp0_cnt++;
                if (sb0.size() == 0) begin
                    fail_now("rsp0_unexpected");
                end else begin
                    e = sb0.pop_front();
                    chk("rsp0_latency", cyc - e.acc, T0);
                    chk("rsp0_rdata", {24'h0, rspd0}, {24'h0, e.rdata});
                end
            end
            if (rspv1) rsp1_cnt++;
        end
    end

    task automatic access0(input logic w, input logic [7:0] ad, input logic [7:0] wd,
                           input logic [7:0] exp_rd, input bit scramble, output int acc);
        logic [15:0] ce_t, we_t, oe_t, bsy_t, rv_t;
        logic [7:0]  pre, rd_pre, rd_hold, dq_exp;
        int          bad_a, bad_dq;
        exp_t        e;
        ce_t = '0; we_t = '0; oe_t = '0; bsy_t = '0; rv_t = '0;
        rd_pre = '0; rd_hold = '0; bad_a = 0; bad_dq = 0;
        rv0 = 1'b1; rwe0 = w; raddr0 = ad; rwd0 = wd;
        wait_ready(0, acc);
        if (acc < 0) begin
            rv0 = 1'b0;
            return;
        end
        pre = last_rd0;
        if (w) shadow0[ad] = wd;
        else last_rd0 = shadow0[ad];
        e.rdata = last_rd0;
        e.acc = acc;
        sb0.push_back(e);
        n_acc0++;
        @(posedge clk);
        #1;
        if (scramble) begin
            raddr0 = ~ad;
            rwd0 = ~wd;
        end else begin
            rv0 = 1'b0;
        end
        for (int c = 1; c < T0; c++) begin
            @(negedge clk);
            ce_t[c]  = !ce0;
            we_t[c]  = !we0;
            oe_t[c]  = !oe0;
            bsy_t[c] = busy0 && !rr0;
            rv_t[c]  = rspv0;
            if (a0 !== ad) bad_a++;
            dq_exp = w ? wd : ((c <= S0 + P0) ? exp_rd : 8'hFF);
            if (dq0 !== dq_exp) bad_dq++;
            if (c == S0 + P0) rd_pre = rspd0;
            if (c == S0 + P0 + 1) rd_hold = rspd0;
        end
        chk("ce_low_cycles", ce_t, mask(1, S0 + P0 + H0));
        chk("we_low_cycles", we_t, w ? mask(S0 + 1, S0 + P0) : 16'h0);
        chk("oe_low_cycles", oe_t, w ? 16'h0 : mask(1, S0 + P0));
        chk("busy_cycles", bsy_t, mask(1, T0 - 1));
        chk("no_early_rsp", rv_t, 16'h0);
        chk("addr_pins_bad_cycles", bad_a, 0);
        chk("dq_bad_cycles", bad_dq, 0);
        chk("rdata_before_capture", {24'h0, rd_pre}, {24'h0, pre});
        chk("rdata_after_pulse", {24'h0, rd_hold}, {24'h0, exp_rd});
        @(posedge clk);
        #1;
    endtask

    task automatic access1(input logic w, input logic [7:0] ad, input logic [7:0] wd,
                           output logic [15:0] we_t, output logic [15:0] ce_t,
                           output logic [15:0] oe_t, output logic [15:0] rv_t,
                           output logic [7:0] rd_end);
        int acc;
        we_t = '0; ce_t = '0; oe_t = '0; rv_t = '0; rd_end = '0;
        rv1 = 1'b1; rwe1 = w; raddr1 = ad; rwd1 = wd;
        wait_ready(1, acc);
        @(posedge clk);
        #1;
        rv1 = 1'b0;
        if (acc < 0) return;
        for (int c = 1; c <= T1; c++) begin
            @(negedge clk);
            we_t[c] = !we1;
            ce_t[c] = !ce1;
            oe_t[c] = !oe1;
            rv_t[c] = rspv1;
            if (c == T1) rd_end = rspd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t        tbl [8];
        int          acc, rel_cyc, rsp1_before;
        logic [15:0] wt, ct, ot, rt;
        logic [7:0]  rd;

        tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00, 2};
        tbl[1] = '{1'b0, 8'h3C, 8'h5A, 8'hA5, 2};
        tbl[2] = '{1'b1, 8'h10, 8'h5A, 8'hA5, 0};
        tbl[3] = '{1'b0, 8'h10, 8'h00, 8'h5A, 0};
        tbl[4] = '{1'b1, 8'h00, 8'hFF, 8'h5A, 0};
        tbl[5] = '{1'b1, 8'hFF, 8'h00, 8'h5A, 1};
        tbl[6] = '{1'b0, 8'h00, 8'h33, 8'hFF, 0};
        tbl[7] = '{1'b0, 8'hFF, 8'hCC, 8'h00, 3};

        // Reset held with a request pending: everything stays idle.
        clr_n = 1'b0;
        rv0 = 1'b1; rwe0 = 1'b1; raddr0 = 8'h3C; rwd0 = 8'hA5;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_{ce,we,oe,ready,rspv,busy}", {ce0, we0, oe0, rr0, rspv0, busy0}, 6'b111100);
        chk("reset_addr", a0, 8'h00);
        chk("reset_rdata", rspd0, 8'h00);
        chk("reset_dq_released", dq0, 8'hFF);
        chk("reset_inst1_strobes", {ce1, we1, oe1, rr1}, 4'b1111);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        rel_cyc = cyc;

        for (int i = 0; i < 8; i++) begin
            access0(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, 1'b0, acc);
            if (i == 0) chk("accept_on_first_edge", acc, rel_cyc);
            repeat (tbl[i].gap) begin
                @(posedge clk);
                #1;
            end
        end

        // Request fields change while busy; only the latched values reach the pins.
        access0(1'b1, 8'h20, 8'h11, 8'h00, 1'b1, acc);
        access0(1'b1, 8'hDF, 8'hEE, 8'h00, 1'b0, acc);
        access0(1'b0, 8'h20, 8'h11, 8'h11, 1'b0, acc);
        access0(1'b0, 8'hDF, 8'hEE, 8'hEE, 1'b0, acc);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("rsp0_count", rsp0_cnt, n_acc0);
        chk("rsp0_pending", sb0.size(), 0);

        // Slow-timing instance: S=2, P=3, H=2.
        access1(1'b1, 8'h44, 8'h99, wt, ct, ot, rt, rd);
        chk("s2p3h2_we_low", wt, mask(S1 + 1, S1 + P1));
        chk("s2p3h2_ce_low", ct, mask(1, S1 + P1 + H1));
        chk("s2p3h2_rsp_at_8", rt, mask(T1, T1));
        access1(1'b0, 8'h44, 8'h00, wt, ct, ot, rt, rd);
        chk("s2p3h2_oe_low", ot, mask(1, S1 + P1));
        chk("s2p3h2_read_rsp", rt, mask(T1, T1));
        chk("s2p3h2_read_data", rd, 8'h99);

        // Reset in the second PULSE cycle of a write aborts it at once.
        rv1 = 1'b1; rwe1 = 1'b1; raddr1 = 8'h55; rwd1 = 8'h77;
        wait_ready(1, acc);
        @(posedge clk);
        #1;
        rv1 = 1'b0;
        repeat (S1 + 1) @(posedge clk);
        #1;
        chk("abort_we_low_before", {ce1, we1}, 2'b00);
        rsp1_before = rsp1_cnt;
        clr_n = 1'b0;
        #1;
        chk("abort_strobes_high", {ce1, we1, oe1}, 3'b111);
        chk("abort_dq_released", dq1, 8'hFF);
        chk("abort_idle", {busy1, rr1}, 2'b01);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        repeat (T1 + 4) @(posedge clk);
        #1;
        chk("abort_no_rsp", rsp1_cnt, rsp1_before);
        chk("strobe_invariants", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
